// File: rtl/alu_share_ctrl.sv
// Round-robin front end that shares one 32-bit combinational ALU among NREQ
// requesters and returns each result on a single registered response channel.
module alu_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [5*NREQ-1:0]  req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_data,
  output logic               rsp_zflag,
  output logic               alu_addsub,
  output logic [1:0]         alu_lgc,
  output logic [1:0]         alu_fn,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  input  logic [31:0]        alu_out,
  input  logic               alu_zflag,
  output logic               busy
);

  localparam int         NSLOT  = 2**IDW;
  localparam logic [1:0] FN_SLT = 2'b01;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [1:0]     fn_q, fn_d;
  logic [1:0]     lgc_q, lgc_d;
  logic           addsub_q, addsub_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_zflag_q, rsp_zflag_d;

  // Requester slots padded to 2**IDW so an IDW-bit index is always in range.
  logic [NSLOT-1:0] valid_pad;
  logic [4:0]       op_slot [NSLOT];
  logic [31:0]      a_slot  [NSLOT];
  logic [31:0]      b_slot  [NSLOT];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NREQ) begin : g_real
        assign valid_pad[gi] = req_valid[gi];
        assign op_slot[gi]   = req_op[5*gi +: 5];
        assign a_slot[gi]    = req_a[32*gi +: 32];
        assign b_slot[gi]    = req_b[32*gi +: 32];
      end else begin : g_pad
        assign valid_pad[gi] = 1'b0;
        assign op_slot[gi]   = 5'd0;
        assign a_slot[gi]    = 32'd0;
        assign b_slot[gi]    = 32'd0;
      end
    end
  endgenerate

  // Scan from last+1 upward with wrap; the first valid requester wins.
  logic [IDW:0]   scan;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, last_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      if (!grant_found && valid_pad[scan[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IDW-1:0];
      end
    end
  end

  logic [4:0]       grant_op;
  logic [NSLOT-1:0] ready_pad;

  assign grant_op = op_slot[grant_idx];

  always_comb begin
    ready_pad = '0;
    if (state_q == IDLE && grant_found) begin
      ready_pad[grant_idx] = 1'b1;
    end
  end

  assign req_ready = ready_pad[NREQ-1:0];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    fn_d        = fn_q;
    lgc_d       = lgc_q;
    addsub_d    = addsub_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_zflag_d = rsp_zflag_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          fn_d     = grant_op[4:3];
          // SLT needs A-B from the adder, whatever the requester asked for.
          addsub_d = grant_op[2] | (grant_op[4:3] == FN_SLT);
          lgc_d    = grant_op[1:0];
          a_d      = a_slot[grant_idx];
          b_d      = b_slot[grant_idx];
          id_d     = grant_idx;
          last_d   = grant_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_zflag_d = alu_zflag;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      fn_q        <= '0;
      lgc_q       <= '0;
      addsub_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_zflag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      fn_q        <= fn_d;
      lgc_q       <= lgc_d;
      addsub_q    <= addsub_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_zflag_q <= rsp_zflag_d;
    end
  end

  assign alu_fn     = fn_q;
  assign alu_lgc    = lgc_q;
  assign alu_addsub = addsub_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_zflag  = rsp_zflag_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU stub, cycle-level reference model of the sharing
// protocol, directed scenarios, then randomized traffic with random backpressure.
module tb_alu_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  typedef logic [IDW-1:0] id_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  id_t                rsp_id;
  logic [31:0]        rsp_data;
  logic               rsp_zflag;
  logic               alu_addsub;
  logic [1:0]         alu_lgc;
  logic [1:0]         alu_fn;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [31:0]        alu_out;
  logic               alu_zflag;
  logic               busy;

  logic [4:0]  op_arr [NREQ];
  logic [31:0] a_arr  [NREQ];
  logic [31:0] b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_op[5*gi +: 5] = op_arr[gi];
    assign req_a[32*gi +: 32] = a_arr[gi];
    assign req_b[32*gi +: 32] = b_arr[gi];
  end

  alu_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zflag(rsp_zflag),
    .alu_addsub(alu_addsub), .alu_lgc(alu_lgc), .alu_fn(alu_fn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zflag(alu_zflag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // The shared ALU itself, driven purely by the controller's alu_* outputs.
  logic [31:0] alu_sum;
  always_comb begin
    alu_sum   = alu_addsub ? (alu_a - alu_b) : (alu_a + alu_b);
    alu_zflag = (alu_sum == 32'd0);
    case (alu_fn)
      2'b01:   alu_out = {31'd0, alu_sum[31]};
      2'b11: begin
        case (alu_lgc)
          2'b00:   alu_out = alu_a & alu_b;
          2'b01:   alu_out = alu_a | alu_b;
          2'b10:   alu_out = alu_a ^ alu_b;
          default: alu_out = ~(alu_a | alu_b);
        endcase
      end
      default: alu_out = alu_sum;
    endcase
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result straight from the op definition: {zero flag, result}.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] adder;
    logic [31:0] res;
    adder = (op[2] || op[4:3] == 2'b01) ? a - b : a + b;
    case (op[4:3])
      2'b01:   res = {31'd0, adder[31]};
      2'b11: begin
        case (op[1:0])
          2'b00:   res = a & b;
          2'b01:   res = a | b;
          2'b10:   res = a ^ b;
          default: res = ~(a | b);
        endcase
      end
      default: res = adder;
    endcase
    return {adder == 32'd0, res};
  endfunction

  function automatic logic [IDW:0] rr_pick(input id_t lst, input logic [NREQ-1:0] v);
    id_t c;
    for (int k = 1; k <= NREQ; k++) begin
      c = id_t'((int'(lst) + k) % NREQ);
      if (v[c]) return {1'b1, c};
    end
    return '0;
  endfunction

  // Reference model: phase 0 idle, 1 executing, 2 response pending.
  bit          m_init = 1'b0;
  int          m_phase = 0;
  id_t         m_last, m_gid, m_id;
  logic [1:0]  m_fn, m_lgc;
  logic        m_addsub, m_z, m_rz;
  logic [31:0] m_a, m_b, m_data, m_res;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] seen_ready = '0;
  logic [IDW:0]    pick;
  int   cyc = 0;
  int   dut_gid[$];
  int   dut_gcyc[$];

  always @(negedge clk) begin
    cyc++;
    seen_ready = req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready == (NREQ'(1) << i)) begin
        dut_gid.push_back(i);
        dut_gcyc.push_back(cyc);
      end
    end
    pick = '0;
    if (m_init) begin
      e_ready = '0;
      if (m_phase == 0) pick = rr_pick(m_last, req_valid);
      if (pick[IDW]) e_ready[pick[IDW-1:0]] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_zflag", 32'(rsp_zflag), 32'(m_z));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_ctl", {27'd0, alu_fn, alu_lgc, alu_addsub}, {27'd0, m_fn, m_lgc, m_addsub});
    end
    if (!rst_n) begin
      m_init = 1'b1;
      m_phase = 0;
      m_last = id_t'(NREQ - 1);
      m_gid = '0; m_id = '0;
      m_fn = '0; m_lgc = '0; m_addsub = 1'b0;
      m_a = '0; m_b = '0; m_data = '0; m_z = 1'b0;
      m_res = '0; m_rz = 1'b0;
    end else if (m_init) begin
      case (m_phase)
        0: if (pick[IDW]) begin
          m_gid = pick[IDW-1:0];
          m_last = m_gid;
          m_fn = op_arr[m_gid][4:3];
          m_lgc = op_arr[m_gid][1:0];
          m_addsub = op_arr[m_gid][2] | (op_arr[m_gid][4:3] == 2'b01);
          m_a = a_arr[m_gid];
          m_b = b_arr[m_gid];
          {m_rz, m_res} = ref_alu(op_arr[m_gid], a_arr[m_gid], b_arr[m_gid]);
          m_phase = 1;
        end
        1: begin
          m_data = m_res; m_z = m_rz; m_id = m_gid;
          m_phase = 2;
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic run_op(input id_t idx, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] d, output logic z,
                        output id_t id, output logic exec_addsub);
    int n;
    @(posedge clk); #1;
    op_arr[idx] = op; a_arr[idx] = a; b_arr[idx] = b;
    req_valid[idx] = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant_onehot", 32'(req_ready), 32'(NREQ'(1) << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    exec_addsub = alu_addsub;
    @(negedge clk);
    chk("latency_t2", 32'(rsp_valid), 32'd1);
    d = rsp_data; z = rsp_zflag; id = rsp_id;
  endtask

  task automatic random_phase(input int ncyc);
    id_t ii;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        ii = id_t'(i);
        if (seen_ready[ii] || (req_valid[ii] && $urandom_range(0, 9) == 0)) begin
          req_valid[ii] = 1'b0;
        end else if (!req_valid[ii] && $urandom_range(0, 2) == 0) begin
          op_arr[ii] = 5'($urandom);
          a_arr[ii] = $urandom;
          b_arr[ii] = ($urandom_range(0, 3) == 0) ? a_arr[ii] : $urandom;
          req_valid[ii] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] d, d0;
  logic        z, xa;
  id_t         id;
  logic [31:0] lgc_exp [4];
  int          g0;
  int          n;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0;
    end
    lgc_exp[0] = 32'hF000F000; lgc_exp[1] = 32'hFFF0FFF0;
    lgc_exp[2] = 32'h0FF00FF0; lgc_exp[3] = 32'h000F000F;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    run_op(2'd0, 5'b00000, 32'd5, 32'd7, d, z, id, xa);
    chk("add_data", d, 32'd12); chk("add_z", 32'(z), 32'd0); chk("add_id", 32'(id), 32'd0);
    run_op(2'd2, 5'b00100, 32'd9, 32'd9, d, z, id, xa);
    chk("sub_data", d, 32'd0); chk("sub_z", 32'(z), 32'd1); chk("sub_id", 32'(id), 32'd2);
    run_op(2'd2, 5'b01000, 32'd3, 32'd5, d, z, id, xa);
    chk("slt_lt_data", d, 32'd1); chk("slt_addsub", 32'(xa), 32'd1);
    run_op(2'd2, 5'b01000, 32'd5, 32'd3, d, z, id, xa);
    chk("slt_ge_data", d, 32'd0);
    for (int l = 0; l < 4; l++) begin
      run_op(2'd1, {3'b110, 2'(l)}, 32'hF0F0F0F0, 32'hFF00FF00, d, z, id, xa);
      chk("logic_data", d, lgc_exp[l]);
    end

    // All four requesting continuously, no backpressure.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = '1; rsp_ready = 1'b1;
    g0 = dut_gid.size();
    n = 0;
    while (dut_gid.size() < g0 + 6 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rr_count", 32'(dut_gid.size() - g0), 32'd6);
    if (dut_gid.size() >= g0 + 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(dut_gid[g0+k]), 32'(k % NREQ));
      for (int k = 1; k < 6; k++) chk("rr_gap", 32'(dut_gcyc[g0+k] - dut_gcyc[g0+k-1]), 32'd3);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Backpressure with req1 waiting behind a held response.
    #1 rsp_ready = 1'b0;
    op_arr[0] = 5'b00000; a_arr[0] = 32'd1; b_arr[0] = 32'd2; req_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    op_arr[1] = 5'b11010; a_arr[1] = 32'h0000FFFF; b_arr[1] = 32'h00FF00FF; req_valid[1] = 1'b1;
    @(negedge clk);
    wait_rsp("bp_wait");
    d0 = rsp_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd3);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    wait_rsp("bp_rsp2");
    chk("bp_data2", rsp_data, 32'h00FFFF00);
    chk("bp_id2", 32'(rsp_id), 32'd1);

    // Reset while req3 is executing.
    @(posedge clk); #1;
    op_arr[3] = 5'b00000; a_arr[3] = 32'd40; b_arr[3] = 32'd2; req_valid[3] = 1'b1;
    @(negedge clk);
    while (!req_ready[3] && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 req_valid[3] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    op_arr[0] = 5'b00000; a_arr[0] = 32'd100; b_arr[0] = 32'd1;
    req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk);
    chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rstx_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("rstx_exec_no_rsp", 32'(rsp_valid), 32'd0);
    wait_rsp("rstx_rsp");
    chk("rstx_id", 32'(rsp_id), 32'd0);
    chk("rstx_data", rsp_data, 32'd101);

    random_phase(800);
    @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one 32-bit combinational ALU among NREQ requesters. The ALU has adder/subtractor, SLT and AND/OR/XOR/NOR functions, plus a zero flag.
- Sequence per operation: round-robin arbitration, operand capture, one execute cycle against the ALU, then a registered response on a single shared response channel with backpressure.
- Sits between requesting units and the ALU instance. It drives the ALU's addsub/lgc/fn/A/B inputs and samples its out/zflag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  one-hot grant/accept (combinational).
- req_op  input  5*NREQ  per-requester op; slice i = bits [5i+4:5i].
- req_a  input  32*NREQ  operand A, slice i.
- req_b  input  32*NREQ  operand B, slice i.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester the response belongs to.
- rsp_data  output  32  ALU result.
- rsp_zflag  output  1  ALU zero flag.
- alu_addsub  output  1  to ALU: 0 add, 1 subtract.
- alu_lgc  output  2  to ALU: 00 AND, 01 OR, 10 XOR, 11 NOR.
- alu_fn  output  2  to ALU result select: 00 add/sub, 01 SLT, 11 logic, 10 reserved (ALU returns sum).
- alu_a, alu_b  output  32  ALU operands.
- alu_out  input  32  ALU result (combinational from alu_* outputs).
- alu_zflag  input  1  ALU zero flag (1 when adder output is zero).
- busy  output  1  high when state is not IDLE.

Behaviour:
- Op format: op[4:3] = fn class, op[2] = addsub, op[1:0] = lgc.
- For fn = 01 (SLT), alu_addsub is forced to 1 regardless of op[2]. SLT result is 32'h1 if the sign bit of (A-B) is 1, else 32'h0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant g = first valid index scanning from (last+1) mod NREQ upward with wrap.
  - req_ready[g] = 1 in the same cycle; all other req_ready bits = 0. The transfer completes that cycle.
  - Latch op/a/b/id into operand registers, set last <= g, go to EXEC.
  - If no req_valid is high, stay in IDLE.
- EXEC:
  - alu_* are driven from the operand registers. They are registered outputs, stable the whole cycle, and hold their last values in every state.
  - At the clock edge: rsp_data <= alu_out, rsp_zflag <= alu_zflag, rsp_id <= latched id, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_id and rsp_zflag are held stable.
  - On rsp_ready = 1: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in EXEC and RESP. Requesters must hold their request until granted.
- Latency: accept at cycle T, rsp_valid high from T+2. Minimum issue interval is 3 cycles (accept in IDLE, EXEC, RESP accepted with rsp_ready high, back to IDLE).
- rsp_zflag is reported exactly as the ALU provides it. It reflects the adder result even for logic ops. The controller does not reinterpret it.
- No overflow/carry is reported; the ALU's overflow output is not connected.
- Reset (rst_n = 0 at a rising edge):
  - state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_zflag = 0.
  - Operand registers = 0, so alu_a = alu_b = 0 and alu_fn = alu_lgc = alu_addsub = 0.
  - last = NREQ-1, so requester 0 has first priority.
- Reset mid-operation (EXEC or RESP) drops the transaction silently; no response is ever produced for it.
- A requester deasserting req_valid while not granted is legal and is simply skipped.
- Only one operation is outstanding at any time.

Test Plan:
- Reset, then req0 op = 00_0_00, A = 5, B = 7 -> req_ready = 4'b0001 at T, rsp_valid at T+2 with rsp_data = 12, rsp_id = 0, rsp_zflag = 0.
- Subtract and SLT via req2:
  - op = 00_1_00, 9-9 -> rsp_data = 0, rsp_zflag = 1, rsp_id = 2.
  - op = 01_0_00 (SLT, addsub forced), A = 3, B = 5 -> rsp_data = 1, and alu_addsub is observed as 1 during EXEC.
  - SLT with A = 5, B = 3 -> rsp_data = 0.
- Logic ops, A = F0F0F0F0, B = FF00FF00, class 11 -> AND F000F000, OR FFF0FFF0, XOR 0FF00FF0, NOR 000F000F.
- All four req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0,1, one grant every 3 cycles, rsp_id matches.
- Backpressure: rsp_ready = 0 for 5 cycles with req1 pending -> rsp_valid/rsp_data/rsp_id stay constant, req_ready stays 0; on release, req1 is granted the cycle after returning to IDLE.
- Reset pulse during EXEC of req3 -> rsp_valid never rises for that op; after reset with req0 and req3 valid, req0 is granted first.
